// File: rtl/keypad_scan_n_if.sv
// Keypad pin and key-event bundle between the board matrix and the scanner.
// The master side is the scanner; the slave side is the matrix/consumer.
interface keypad_scan_n_if #(
  parameter int ROWS = 4,
  parameter int COLS = 4
);
  localparam int CW = $clog2(ROWS * COLS);

  logic [COLS-1:0] columna;
  logic [ROWS-1:0] fila;
  logic [CW:0]     key;
  logic            keypad_pressed;

  modport master (input columna, output fila, output key, output keypad_pressed);
  modport slave  (output columna, input fila, input key, input keypad_pressed);
endinterface

// File: rtl/keypad_scan_n.sv
// Parametrised matrix keypad scanner: synchronised, debounced press/release, lowest-index
// priority. Define KEYPAD_REPEAT_EN to add auto-repeat strobes while a key stays held.
module keypad_scan_n #(
  parameter int ROWS          = 4,
  parameter int COLS          = 4,
  parameter int SCAN_DIV      = 1000,
  parameter int DEB_CYCLES    = 20000,
  parameter int REPEAT_DELAY  = 25000000,
  parameter int REPEAT_PERIOD = 5000000
) (
  input logic             clk,
  input logic             rst_n,
  keypad_scan_n_if.master kp
);
  localparam int CW  = $clog2(ROWS * COLS);
  localparam int RW  = $clog2(ROWS);
  localparam int CCW = $clog2(COLS);
  localparam int SW  = $clog2(SCAN_DIV);
  localparam int DW  = $clog2(DEB_CYCLES + 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);
  localparam logic [SW-1:0] DIV_LAST = SW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);

  if (ROWS < 2 || ROWS > 8 || COLS < 2 || COLS > 8 || SCAN_DIV < 4 || DEB_CYCLES < 2 ||
      REPEAT_DELAY < 1 || REPEAT_PERIOD < 2) begin : g_param_check
    $error("keypad_scan_n: parameter out of range");
  end

  typedef enum logic [1:0] {SCAN, DEB_PRESS, HELD, DEB_REL} state_t;

  state_t          state, state_nxt;
  logic [COLS-1:0] sync1, sync2, col_s;
  logic [RW-1:0]   row, row_nxt, next_row;
  logic [SW-1:0]   div_cnt, div_nxt;
  logic [DW-1:0]   deb_cnt, deb_nxt;
  logic [CCW-1:0]  lat_col, lat_col_nxt, low_col;
  logic [COLS-1:0] lat_pat, lat_pat_nxt;
  logic            key_held, key_held_nxt;
  logic [CW-1:0]   key_code, key_code_nxt;
  logic            pressed, pressed_nxt;
  logic            any_low;
`ifdef KEYPAD_REPEAT_EN
  localparam logic [31:0] REP_D = 32'(REPEAT_DELAY);
  localparam logic [31:0] REP_P = 32'(REPEAT_PERIOD);
  logic [31:0] rep_cnt, rep_cnt_nxt, rep_tgt, rep_tgt_nxt;
`endif

  assign col_s    = sync2;
  assign next_row = (row == ROW_LAST) ? '0 : row + RW'(1);

  always_comb begin
    any_low = 1'b0;
    low_col = '0;
    for (int unsigned i = 0; i < COLS; i++) begin
      if (!col_s[CCW'(i)] && !any_low) begin
        any_low = 1'b1;
        low_col = CCW'(i);
      end
    end
  end

  always_comb begin
    state_nxt    = state;
    row_nxt      = row;
    div_nxt      = div_cnt;
    deb_nxt      = deb_cnt;
    lat_col_nxt  = lat_col;
    lat_pat_nxt  = lat_pat;
    key_held_nxt = key_held;
    key_code_nxt = key_code;
    pressed_nxt  = 1'b0;
    case (state)
      SCAN: begin
        if (div_cnt == DIV_LAST) begin
          div_nxt = '0;
          if (any_low) begin
            state_nxt   = DEB_PRESS;
            lat_col_nxt = low_col;
            lat_pat_nxt = col_s;
            deb_nxt     = '0;
          end else begin
            row_nxt = next_row;
          end
        end else begin
          div_nxt = div_cnt + SW'(1);
        end
      end
      DEB_PRESS: begin
        if (!col_s[lat_col] && (col_s == lat_pat)) begin
          if (deb_cnt == DEB_LAST) begin
            state_nxt    = HELD;
            key_held_nxt = 1'b1;
            key_code_nxt = CW'(int'(row) * COLS + int'(lat_col));
            pressed_nxt  = 1'b1;
            deb_nxt      = '0;
          end else begin
            deb_nxt = deb_cnt + DW'(1);
          end
        end else begin
          state_nxt = SCAN;
          row_nxt   = next_row;
          div_nxt   = '0;
        end
      end
      HELD: begin
        if (col_s[lat_col]) begin
          state_nxt = DEB_REL;
          deb_nxt   = '0;
        end
      end
      DEB_REL: begin
        if (col_s[lat_col]) begin
          if (deb_cnt == DEB_LAST) begin
            state_nxt    = SCAN;
            key_held_nxt = 1'b0;
            row_nxt      = next_row;
            div_nxt      = '0;
          end else begin
            deb_nxt = deb_cnt + DW'(1);
          end
        end else begin
          state_nxt = HELD;
        end
      end
      default: state_nxt = SCAN;
    endcase
`ifdef KEYPAD_REPEAT_EN
    // Counter runs through DEB_REL bounces; a repeat due during DEB_REL fires on return to HELD.
    rep_cnt_nxt = rep_cnt;
    rep_tgt_nxt = rep_tgt;
    if (state == HELD || state == DEB_REL) begin
      rep_cnt_nxt = rep_cnt + 32'd1;
      if (state == HELD && (rep_cnt + 32'd1 >= rep_tgt)) begin
        pressed_nxt = 1'b1;
        rep_cnt_nxt = '0;
        rep_tgt_nxt = REP_P;
      end
    end else begin
      rep_cnt_nxt = '0;
      rep_tgt_nxt = REP_D;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1    <= '1;
      sync2    <= '1;
      state    <= SCAN;
      row      <= '0;
      div_cnt  <= '0;
      deb_cnt  <= '0;
      lat_col  <= '0;
      lat_pat  <= '1;
      key_held <= 1'b0;
      key_code <= '0;
      pressed  <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      rep_cnt  <= '0;
      rep_tgt  <= REP_D;
`endif
    end else begin
      sync1    <= kp.columna;
      sync2    <= sync1;
      state    <= state_nxt;
      row      <= row_nxt;
      div_cnt  <= div_nxt;
      deb_cnt  <= deb_nxt;
      lat_col  <= lat_col_nxt;
      lat_pat  <= lat_pat_nxt;
      key_held <= key_held_nxt;
      key_code <= key_code_nxt;
      pressed  <= pressed_nxt;
`ifdef KEYPAD_REPEAT_EN
      rep_cnt  <= rep_cnt_nxt;
      rep_tgt  <= rep_tgt_nxt;
`endif
    end
  end

  assign kp.fila           = ~(ROWS'(1) << row);
  assign kp.key            = {key_held, key_code};
  assign kp.keypad_pressed = pressed;
endmodule

// File: tb/tb_keypad_scan_n.sv
// Bench for keypad_scan_n: key matrix modelled from fila, scoreboard of expected strobes.
module tb_keypad_scan_n;
  localparam int ROWS = 4, COLS = 4, SCAN_DIV = 4, DEB_CYCLES = 8;
  localparam int REPEAT_DELAY = 40, REPEAT_PERIOD = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] keys = '0;
  int          tests = 0, failed = 0, cyc = 0, strobe_cnt = 0;
  logic [3:0]  exp_q[$];
  int          strobe_cyc[$];
  logic        prev_p = 1'b0;

  always #5 clk = ~clk;

  keypad_scan_n_if #(.ROWS(ROWS), .COLS(COLS)) kif ();

  keypad_scan_n #(
    .ROWS(ROWS), .COLS(COLS), .SCAN_DIV(SCAN_DIV), .DEB_CYCLES(DEB_CYCLES),
    .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .kp(kif.master)
  );

  // A pressed key pulls its column low only while its row is driven low.
  always_comb begin
    kif.columna = '1;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (keys[4'(r * COLS + c)] && !kif.fila[2'(r)]) kif.columna[2'(c)] = 1'b0;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (kif.keypad_pressed) begin
        strobe_cnt++;
        strobe_cyc.push_back(cyc);
        check("strobe_gap", 32'(prev_p), 32'd0);
        if (exp_q.size() == 0) begin
          tests++;
          failed++;
          $display("FAIL unexpected_strobe: got strobe with key=%b, required none", kif.key);
        end else begin
          check("strobe_key", 32'(kif.key), 32'({1'b1, exp_q.pop_front()}));
        end
      end
      prev_p = kif.keypad_pressed;
    end else begin
      prev_p = 1'b0;
    end
  end

  task automatic wait_strobe(input int lim, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < lim && !ok; i++) begin
      @(negedge clk);
      if (kif.keypad_pressed) ok = 1'b1;
    end
  endtask

  task automatic wait_fila(input logic [3:0] val, input int lim, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < lim && !ok; i++) begin
      @(negedge clk);
      if (kif.fila == val) ok = 1'b1;
    end
  endtask

  task automatic wait_rel(input int lim, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < lim && !ok; i++) begin
      @(negedge clk);
      if (!kif.key[4]) ok = 1'b1;
    end
  endtask

  typedef struct {
    logic [15:0] mask;
    logic [3:0]  code;
    logic [3:0]  fila_held;
    logic [3:0]  fila_after;
  } vec_t;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no finish, required finish");
    $fatal(1);
  end

  initial begin
    vec_t       vt[6];
    logic [3:0] step_exp[5];
    int         offs[5];
    logic       ok;
    int         s0, n_rep;

    vt[0] = '{16'h0200, 4'd9,  4'b1011, 4'b0111};  // r2c1
    vt[1] = '{16'h8000, 4'd15, 4'b0111, 4'b1110};  // r3c3
    vt[2] = '{16'h0001, 4'd0,  4'b1110, 4'b1101};  // r0c0
    vt[3] = '{16'h0040, 4'd6,  4'b1101, 4'b1011};  // r1c2
    vt[4] = '{16'h0006, 4'd1,  4'b1110, 4'b1101};  // r0c1+r0c2
    vt[5] = '{16'h0810, 4'd4,  4'b1101, 4'b1011};  // r1c0+r2c3, row 1 scanned first
    step_exp = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};
    offs = '{0, 40, 56, 72, 88};

    // Reset values and free-running row scan
    repeat (3) @(negedge clk);
    check("rst_fila", 32'(kif.fila), 32'(step_exp[0]));
    check("rst_key", 32'(kif.key), 32'd0);
    check("rst_pressed", 32'(kif.keypad_pressed), 32'd0);
    rst_n = 1'b1;
    for (int i = 1; i < 5; i++) begin
      repeat (4) @(negedge clk);
      check($sformatf("scan_step%0d", i), 32'(kif.fila), 32'(step_exp[i]));
    end

    // Press / hold / release vectors; next press follows the release edge directly
    for (int v = 0; v < 6; v++) begin
      exp_q.push_back(vt[v].code);
      keys = vt[v].mask;
      wait_strobe(200, ok);
      check($sformatf("press_seen%0d", v), 32'(ok), 32'd1);
      check($sformatf("press_key%0d", v), 32'(kif.key), 32'({1'b1, vt[v].code}));
      check($sformatf("press_fila%0d", v), 32'(kif.fila), 32'(vt[v].fila_held));
      repeat (20) @(negedge clk);
      check($sformatf("hold_fila%0d", v), 32'(kif.fila), 32'(vt[v].fila_held));
      keys = '0;
      repeat (8) @(negedge clk);
      check($sformatf("rel_early%0d", v), 32'(kif.key[4]), 32'd1);
      wait_rel(8, ok);
      check($sformatf("rel_seen%0d", v), 32'(ok), 32'd1);
      check($sformatf("rel_key%0d", v), 32'(kif.key), 32'({1'b0, vt[v].code}));
      check($sformatf("rel_fila%0d", v), 32'(kif.fila), 32'(vt[v].fila_after));
    end

    // Bounce on r2c1 starting at row-2 dwell: low 5, high 1, low 3, released
    wait_fila(4'b0111, 40, ok);
    wait_fila(4'b1011, 40, ok);
    check("bounce_sync", 32'(ok), 32'd1);
    s0 = strobe_cnt;
    keys = 16'h0200; repeat (5) @(negedge clk);
    keys = '0;       @(negedge clk);
    keys = 16'h0200; repeat (3) @(negedge clk);
    keys = '0;
    repeat (20) @(negedge clk);
    check("bounce_nostrobe", 32'(strobe_cnt), 32'(s0));
    check("bounce_key", 32'(kif.key), 32'h04);
    wait_fila(4'b1110, 40, ok);
    check("bounce_scan_resumes", 32'(ok), 32'd1);

    // Release with a re-low glitch on r3c3
    exp_q.push_back(4'd15);
    keys = 16'h8000;
    wait_strobe(200, ok);
    check("glitch_press_seen", 32'(ok), 32'd1);
    #1 s0 = strobe_cnt;
    keys = '0;       repeat (3) @(negedge clk);
    keys = 16'h8000; repeat (4) @(negedge clk);
    check("glitch_still_held", 32'(kif.key), 32'h1f);
    keys = '0;
    wait_rel(20, ok);
    check("glitch_rel_seen", 32'(ok), 32'd1);
    check("glitch_rel_key", 32'(kif.key), 32'h0f);
    check("glitch_no_second", 32'(strobe_cnt), 32'(s0));

    // Async reset in the middle of press debounce (r0c1+r0c2)
    wait_fila(4'b0111, 40, ok);
    wait_fila(4'b1110, 40, ok);
    s0 = strobe_cnt;
    keys = 16'h0006;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_fila", 32'(kif.fila), 32'hE);
    check("midrst_key", 32'(kif.key), 32'd0);
    check("midrst_pressed", 32'(kif.keypad_pressed), 32'd0);
    repeat (3) @(negedge clk);
    keys = '0;
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("midrst_nostrobe", 32'(strobe_cnt), 32'(s0));
    check("midrst_key_after", 32'(kif.key), 32'd0);

    // Held key 5 for 100 clocks: auto-repeat only when enabled
`ifdef KEYPAD_REPEAT_EN
    n_rep = 5;
`else
    n_rep = 1;
`endif
    for (int i = 0; i < n_rep; i++) exp_q.push_back(4'd5);
    strobe_cyc.delete();
    keys = 16'h0020;
    wait_strobe(200, ok);
    check("rep_first_seen", 32'(ok), 32'd1);
    repeat (100) @(negedge clk);
    keys = '0;
    wait_rel(20, ok);
    check("rep_rel_seen", 32'(ok), 32'd1);
    repeat (5) @(negedge clk);
    check("rep_count", 32'(strobe_cyc.size()), 32'(n_rep));
    for (int i = 1; i < n_rep && i < strobe_cyc.size(); i++)
      check($sformatf("rep_offset%0d", i), 32'(strobe_cyc[i] - strobe_cyc[0]), 32'(offs[i]));

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
